// File: rtl/risc_datapath_if.sv
// Control strobes and result path between the RISC controller and its datapath.
// The controller drives the master side; the datapath implements the slave side.
interface risc_datapath_if;
  logic [2:0]  readnum;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [2:0]  writenum;
  logic        write;
  logic [15:0] datapath_in;
  logic        Z_out;
  logic [15:0] datapath_out;

  modport master (
    output readnum, vsel, loada, loadb, shift, asel, bsel, ALUop,
           loadc, loads, writenum, write, datapath_in,
    input  Z_out, datapath_out
  );

  modport slave (
    input  readnum, vsel, loada, loadb, shift, asel, bsel, ALUop,
           loadc, loads, writenum, write, datapath_in,
    output Z_out, datapath_out
  );
endinterface

// File: rtl/risc_datapath.sv
// 16-bit RISC datapath: 8x16 register file, A/B operand registers, shifter,
// operand muxes, ALU, result register C and zero flag Z.
module risc_datapath (
  input  logic            clk,
  input  logic            reset,
  risc_datapath_if.slave  dp
);

  logic [15:0] regs_r [8];
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] c_r;
  logic        z_r;

  logic [15:0] data_out_s;
  logic [15:0] wb_data_s;
  logic [15:0] shift_out_s;
  logic [15:0] ain_s;
  logic [15:0] bin_s;
  logic [15:0] alu_out_s;
  logic        zero_s;

  // Register-file read port, writeback mux and operand selection.
  always_comb begin
    data_out_s = regs_r[dp.readnum];
    wb_data_s  = 16'd0;
    ain_s      = 16'd0;
    bin_s      = 16'd0;
    if (dp.vsel) begin
      wb_data_s = dp.datapath_in;
    end else begin
      wb_data_s = c_r;
    end
    if (dp.asel) begin
      ain_s = 16'd0;
    end else begin
      ain_s = a_r;
    end
    if (dp.bsel) begin
      bin_s = {11'b0, dp.datapath_in[4:0]};
    end else begin
      bin_s = shift_out_s;
    end
  end

  // Shifter on B.
  always_comb begin
    shift_out_s = b_r;
    case (dp.shift)
      2'b00:   shift_out_s = b_r;
      2'b01:   shift_out_s = {b_r[14:0], 1'b0};
      2'b10:   shift_out_s = {1'b0, b_r[15:1]};
      2'b11:   shift_out_s = {b_r[15], b_r[15:1]};
      default: shift_out_s = b_r;
    endcase
  end

  // ALU and zero detect; arithmetic wraps modulo 2^16.
  always_comb begin
    alu_out_s = 16'd0;
    case (dp.ALUop)
      2'b00:   alu_out_s = ain_s + bin_s;
      2'b01:   alu_out_s = ain_s - bin_s;
      2'b10:   alu_out_s = ain_s & bin_s;
      2'b11:   alu_out_s = ~bin_s;
      default: alu_out_s = 16'd0;
    endcase
    zero_s = (alu_out_s == 16'd0);
  end

  // All architectural state; every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 16'd0;
      end
      a_r <= 16'd0;
      b_r <= 16'd0;
      c_r <= 16'd0;
      z_r <= 1'b0;
    end else begin
      if (dp.write) begin
        regs_r[dp.writenum] <= wb_data_s;
      end
      if (dp.loada) begin
        a_r <= data_out_s;
      end
      if (dp.loadb) begin
        b_r <= data_out_s;
      end
      if (dp.loadc) begin
        c_r <= alu_out_s;
      end
      if (dp.loads) begin
        z_r <= zero_s;
      end
    end
  end

  assign dp.datapath_out = c_r;
  assign dp.Z_out        = z_r;

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed vector table from the test plan,
// then random control strobes checked against an arithmetic reference model.
module tb_risc_datapath;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  risc_datapath_if dp ();

  risc_datapath dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  rn;
    logic        vsel;
    logic        la;
    logic        lb;
    logic [1:0]  sh;
    logic        as;
    logic        bs;
    logic [1:0]  op;
    logic        lc;
    logic        ls;
    logic [2:0]  wn;
    logic        wr;
    logic [15:0] din;
    logic [15:0] eout;
    logic        ez;
  } vec_t;

  int checks;
  int failures;

  int unsigned m_reg [8];
  int unsigned m_a;
  int unsigned m_b;
  int unsigned m_c;
  int unsigned m_z;

  function automatic vec_t v(input logic rst, input logic [2:0] rn, input logic vsel,
                             input logic la, input logic lb, input logic [1:0] sh,
                             input logic as, input logic bs, input logic [1:0] op,
                             input logic lc, input logic ls, input logic [2:0] wn,
                             input logic wr, input logic [15:0] din,
                             input logic [15:0] eout, input logic ez);
    vec_t r;
    r.rst = rst; r.rn = rn; r.vsel = vsel; r.la = la; r.lb = lb; r.sh = sh;
    r.as = as; r.bs = bs; r.op = op; r.lc = lc; r.ls = ls; r.wn = wn;
    r.wr = wr; r.din = din; r.eout = eout; r.ez = ez;
    return r;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of strobes, advance the reference model, and clock the DUT.
  task automatic apply(input vec_t t);
    int unsigned sh_v, ain, bin, alu, rd, wb;
    reset          = t.rst;
    dp.readnum     = t.rn;
    dp.vsel        = t.vsel;
    dp.loada       = t.la;
    dp.loadb       = t.lb;
    dp.shift       = t.sh;
    dp.asel        = t.as;
    dp.bsel        = t.bs;
    dp.ALUop       = t.op;
    dp.loadc       = t.lc;
    dp.loads       = t.ls;
    dp.writenum    = t.wn;
    dp.write       = t.wr;
    dp.datapath_in = t.din;
    case (t.sh)
      2'd0:    sh_v = m_b;
      2'd1:    sh_v = (m_b * 2) % 65536;
      2'd2:    sh_v = m_b / 2;
      default: sh_v = m_b / 2 + ((m_b >= 32768) ? 32768 : 0);
    endcase
    ain = t.as ? 0 : m_a;
    bin = t.bs ? (int'(t.din) % 32) : sh_v;
    case (t.op)
      2'd0:    alu = (ain + bin) % 65536;
      2'd1:    alu = (ain + 65536 - bin) % 65536;
      2'd2:    alu = ain & bin;
      default: alu = 65535 - bin;
    endcase
    rd = m_reg[t.rn];
    wb = t.vsel ? int'(t.din) : m_c;
    @(posedge clk);
    if (t.rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      m_a = 0; m_b = 0; m_c = 0; m_z = 0;
    end else begin
      if (t.wr) m_reg[t.wn] = wb;
      if (t.la) m_a = rd;
      if (t.lb) m_b = rd;
      if (t.lc) m_c = alu;
      if (t.ls) m_z = (alu == 0) ? 1 : 0;
    end
    #1;
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_a = 0; m_b = 0; m_c = 0; m_z = 0;

    //          rst  rn    vsel la   lb   sh     as   bs   op     lc   ls   wn    wr   din        eout       ez
    tbl.push_back(v(1'b1,3'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'h0000,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b1,16'd7,   16'h0000,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd1,1'b1,16'd2,   16'h0000,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'h0000,1'b0));
    tbl.push_back(v(1'b0,3'd1,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'h0000,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd1,1'b0,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'd16,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd2,1'b1,16'h0000,16'd16,  1'b0));
    tbl.push_back(v(1'b0,3'd2,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'd16,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'd16,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd4,1'b1,16'h0000,16'd16,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b1,2'd0,1'b1,1'b0,3'd0,1'b0,16'hFFFF,16'd31,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd5,1'b1,16'h0000,16'd31,  1'b0));
    // read back R4, R5 and untouched R3 through B
    tbl.push_back(v(1'b0,3'd4,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'd31,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'd16,  1'b0));
    tbl.push_back(v(1'b0,3'd5,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'd16,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'd31,  1'b0));
    tbl.push_back(v(1'b0,3'd3,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'd31,  1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b1,3'd0,1'b0,16'h0000,16'h0000,1'b1));
    // shifter: B = 8002, arithmetic then logical right shift
    tbl.push_back(v(1'b0,3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd6,1'b1,16'h8002,16'h0000,1'b1));
    tbl.push_back(v(1'b0,3'd6,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'h0000,1'b1));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd3,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'hC001,1'b1));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd2,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'h4001,1'b1));
    // SUB 5-5 sets Z, NOT 0 clears Z
    tbl.push_back(v(1'b0,3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd7,1'b1,16'd5,   16'h4001,1'b1));
    tbl.push_back(v(1'b0,3'd7,1'b0,1'b1,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'h4001,1'b1));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd1,1'b1,1'b1,3'd0,1'b0,16'h0000,16'h0000,1'b1));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,2'd3,1'b1,1'b1,3'd0,1'b0,16'h0000,16'hFFFF,1'b0));
    // AND 0F0F & 00FF
    tbl.push_back(v(1'b0,3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b1,16'h0F0F,16'hFFFF,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd1,1'b1,16'h00FF,16'hFFFF,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'hFFFF,1'b0));
    tbl.push_back(v(1'b0,3'd1,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'hFFFF,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,2'd2,1'b1,1'b1,3'd0,1'b0,16'h0000,16'h000F,1'b0));
    // writeback of old C while C loads; then read-during-write returns old R3
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b1,2'd0,1'b1,1'b0,3'd3,1'b1,16'd9,   16'd9,   1'b0));
    tbl.push_back(v(1'b0,3'd3,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'd9,   1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'h000F,1'b0));
    tbl.push_back(v(1'b0,3'd3,1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd3,1'b1,16'h1234,16'h000F,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'h000F,1'b0));
    tbl.push_back(v(1'b0,3'd3,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'h000F,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b0,3'd0,1'b0,16'h0000,16'h1234,1'b0));
    // reset overrides simultaneous strobes
    tbl.push_back(v(1'b1,3'd3,1'b1,1'b1,1'b1,2'd0,1'b1,1'b1,2'd0,1'b1,1'b1,3'd3,1'b1,16'd5,   16'h0000,1'b0));
    tbl.push_back(v(1'b0,3'd3,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,3'd0,1'b0,16'h0000,16'h0000,1'b0));
    tbl.push_back(v(1'b0,3'd0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b1,1'b1,3'd0,1'b0,16'h0000,16'h0000,1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d_out", i), dp.datapath_out, tbl[i].eout);
      check($sformatf("vec%0d_z", i), dp.Z_out, tbl[i].ez);
    end

    for (int n = 0; n < 600; n++) begin
      rv.rst  = ($urandom_range(0, 49) == 0);
      rv.rn   = 3'($urandom_range(0, 7));
      rv.vsel = 1'($urandom_range(0, 1));
      rv.la   = 1'($urandom_range(0, 1));
      rv.lb   = 1'($urandom_range(0, 1));
      rv.sh   = 2'($urandom_range(0, 3));
      rv.as   = ($urandom_range(0, 3) == 0);
      rv.bs   = ($urandom_range(0, 3) == 0);
      rv.op   = 2'($urandom_range(0, 3));
      rv.lc   = 1'($urandom_range(0, 1));
      rv.ls   = 1'($urandom_range(0, 1));
      rv.wn   = 3'($urandom_range(0, 7));
      rv.wr   = 1'($urandom_range(0, 1));
      rv.din  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rv.eout = 16'h0000;
      rv.ez   = 1'b0;
      apply(rv);
      check($sformatf("rnd%0d_out", n), dp.datapath_out, m_c);
      check($sformatf("rnd%0d_z", n), dp.Z_out, m_z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
